// File: rtl/tcb_lib_logsize2byteena_split_if.sv
// Bus interfaces for the log-size to byte-enable splitter.
// tcb_ls_if carries the log-size side: access size is sent as log2(bytes).
// tcb_be_if carries the byte-enable side: word-aligned address plus lane enables.

interface tcb_ls_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BEN = DW / 8;
    localparam int MAX = $clog2(BEN);
    localparam int SW  = $clog2(MAX + 1);

    logic          vld;
    logic          rdy;
    logic          wen;
    logic [AW-1:0] adr;
    logic [SW-1:0] siz;
    logic [DW-1:0] wdt;
    logic          rsp;
    logic [DW-1:0] rdt;
    logic          err;

    modport master (output vld, wen, adr, siz, wdt, input  rdy, rsp, rdt, err);
    modport slave  (input  vld, wen, adr, siz, wdt, output rdy, rsp, rdt, err);
endinterface

interface tcb_be_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    localparam int BEN = DW / 8;

    logic           vld;
    logic           rdy;
    logic           wen;
    logic [AW-1:0]  adr;
    logic [BEN-1:0] ben;
    logic [DW-1:0]  wdt;
    logic [DW-1:0]  rdt;
    logic           err;

    modport master (output vld, wen, adr, ben, wdt, input  rdy, rdt, err);
    modport slave  (input  vld, wen, adr, ben, wdt, output rdy, rdt, err);
endinterface

// File: rtl/tcb_lib_logsize2byteena_split.sv
// Log-size to byte-enable converter (little-endian).
// Accesses crossing a data-word boundary become two aligned manager beats;
// the two read responses are merged into one subordinate response.

module tcb_lib_logsize2byteena_split #(
    parameter int AW  = 32,
    parameter int DW  = 32,
    parameter int DLY = 1
)(
    input  logic     clk,
    input  logic     rst_n,
    tcb_ls_if.slave  sub,
    tcb_be_if.master man
);
    localparam int BEN = DW / 8;
    localparam int MAX = $clog2(BEN);
    localparam int SW  = $clog2(MAX + 1);
    localparam int EW  = MAX + 2;

    typedef enum logic {ST_IDLE, ST_SECOND} state_t;

    // One entry per manager handshake, aligned with its response.
    typedef struct packed {
        logic           vld;
        logic           first;
        logic           last;
        logic [MAX-1:0] off;
        logic [SW-1:0]  siz;
    } rec_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_man_vld;
    logic           w_sub_rdy;
    logic           w_second;
    logic [SW-1:0]  w_siz;
    logic [MAX-1:0] w_off;
    logic [EW-1:0]  w_end;
    logic           w_cross;
    logic [AW-1:0]  w_adr_lo;
    logic [AW-1:0]  w_adr_hi;
    logic [BEN-1:0] w_ben;
    logic [DW-1:0]  w_wdt;
    logic [MAX-1:0] v_src;
    rec_t           w_rec_in;
    rec_t           w_rec_out;
    logic [DW-1:0]  r_hold;
    logic           r_herr;
    logic           w_rsp;
    logic           w_split;
    logic [EW-1:0]  w_rlen;
    logic [DW-1:0]  w_merged;
    logic [DW-1:0]  w_rdt;
    logic [MAX-1:0] v_sel;

    // Oversized requests are clamped to a full word.
    assign w_siz    = (sub.siz > SW'(MAX)) ? SW'(MAX) : sub.siz;
    assign w_off    = sub.adr[MAX-1:0];
    assign w_end    = {2'b00, w_off} + (EW'(1) << w_siz);
    assign w_cross  = (w_end > EW'(BEN));
    assign w_adr_lo = {sub.adr[AW-1:MAX], MAX'(0)};
    assign w_adr_hi = w_adr_lo + AW'(BEN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state and handshake steering.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a latch behind.
        w_state_nxt = r_state;
        w_man_vld   = 1'b0;
        w_sub_rdy   = 1'b0;
        w_second    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_man_vld = sub.vld;
                w_sub_rdy = w_cross ? 1'b0 : man.rdy;
                if (sub.vld && man.rdy && w_cross) w_state_nxt = ST_SECOND;
            end
            ST_SECOND: begin
                w_man_vld = 1'b1;
                w_sub_rdy = man.rdy;
                w_second  = 1'b1;
                if (man.rdy) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Lane enables for the current beat and write data rotated onto byte lanes.
    always_comb begin
        w_ben = '0;
        w_wdt = '0;
        v_src = '0;
        for (int i = 0; i < BEN; i++) begin
            if (w_second) w_ben[i] = (EW'(i + BEN) < w_end);
            else          w_ben[i] = (EW'(i) >= {2'b00, w_off}) && (EW'(i) < w_end);
            v_src = MAX'(i) - w_off;
            w_wdt[8*i +: 8] = sub.wdt[8*int'(v_src) +: 8];
        end
    end

    // Every output is forced low while reset is held.
    assign man.vld = rst_n & w_man_vld;
    assign man.wen = rst_n & sub.wen;
    assign man.adr = rst_n ? (w_second ? w_adr_hi : w_adr_lo) : '0;
    assign man.ben = rst_n ? w_ben : '0;
    assign man.wdt = rst_n ? w_wdt : '0;
    assign sub.rdy = rst_n & w_sub_rdy;

    assign w_rec_in = '{vld:   w_man_vld & man.rdy,
                        first: ~w_second,
                        last:  w_second | ~w_cross,
                        off:   w_off,
                        siz:   w_siz};

    generate
        if (DLY == 0) begin : g_nodly
            assign w_rec_out = w_rec_in;
        end else begin : g_dly
            rec_t r_pipe [DLY];
            // Delay line matching the manager response latency.
            always_ff @(posedge clk or negedge rst_n) begin
                // NOTE: this small array is reset on purpose; a stale vld bit would emit a phantom response.
                if (!rst_n) begin
                    for (int i = 0; i < DLY; i++) r_pipe[i] <= '0;
                end else begin
                    r_pipe[0] <= w_rec_in;
                    for (int i = 1; i < DLY; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end
            assign w_rec_out = r_pipe[DLY-1];
        end
    endgenerate

    // Capture the first half of a split read until its second half returns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_herr <= 1'b0;
        end else if (w_rec_out.vld && w_rec_out.first && !w_rec_out.last) begin
            r_hold <= man.rdt;
            r_herr <= man.err;
        end
    end

    assign w_rsp   = rst_n & w_rec_out.vld & w_rec_out.last;
    assign w_split = w_rec_out.vld & ~w_rec_out.first;
    assign w_rlen  = EW'(1) << w_rec_out.siz;

    // Merge held and live lanes, then rotate back to LSB-aligned and zero-fill.
    always_comb begin
        w_merged = '0;
        w_rdt    = '0;
        v_sel    = '0;
        for (int k = 0; k < BEN; k++) begin
            w_merged[8*k +: 8] = (w_split && (MAX'(k) >= w_rec_out.off)) ? r_hold[8*k +: 8]
                                                                        : man.rdt[8*k +: 8];
        end
        for (int j = 0; j < BEN; j++) begin
            v_sel = MAX'(j) + w_rec_out.off;
            if (EW'(j) < w_rlen) w_rdt[8*j +: 8] = w_merged[8*int'(v_sel) +: 8];
        end
    end

    assign sub.rsp = w_rsp;
    assign sub.rdt = w_rsp ? w_rdt : '0;
    assign sub.err = w_rsp & (man.err | (w_split & r_herr));

    a_siz_legal: assert property (@(posedge clk) disable iff (!rst_n)
        sub.vld |-> (sub.siz <= SW'(MAX)));

    a_req_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (sub.vld && !sub.rdy) |=> (!rst_n || (sub.vld && $stable(sub.wen) && $stable(sub.adr)
                                              && $stable(sub.siz) && $stable(sub.wdt))));

    a_second_vld: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_SECOND) |-> sub.vld);

endmodule

// File: tb/tb_tcb_lib_logsize2byteena_split.sv
// Bench for tcb_lib_logsize2byteena_split (DW=32, DLY=1).
// Table-driven requests with a scoreboard for manager beats and subordinate
// responses, followed by hand-written stall and reset-in-split sequences.

module tb_tcb_lib_logsize2byteena_split;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int DLY = 1;
    localparam int NV  = 11;

    typedef struct {
        logic        wen;
        logic [31:0] adr;
        logic [1:0]  siz;
        logic [31:0] wdt;
        logic [31:0] rdt1;
        logic [31:0] rdt2;
        logic        err1;
        logic        err2;
        int          nbeats;
        logic [31:0] adr1;
        logic [3:0]  ben1;
        logic [31:0] adr2;
        logic [3:0]  ben2;
        logic [31:0] mwdt;
        logic [31:0] exp_rdt;
        logic        exp_err;
        int          stall;
    } vec_t;

    typedef struct { logic [31:0] adr; logic [3:0] ben; logic wen; logic [31:0] wdt; } beat_t;
    typedef struct { logic [31:0] rdt; logic err; } data_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   n_rsp;

    beat_t beat_q[$];
    data_t data_q[$];
    data_t rsp_q[$];
    vec_t  vecs[NV];

    tcb_ls_if #(.AW(AW), .DW(DW)) sub_if ();
    tcb_be_if #(.AW(AW), .DW(DW)) man_if ();

    tcb_lib_logsize2byteena_split #(.AW(AW), .DW(DW), .DLY(DLY)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sub   (sub_if),
        .man   (man_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_sub_rdy"}, 64'(sub_if.rdy), 64'(0));
        check({tag, "_man_vld"}, 64'(man_if.vld), 64'(0));
        check({tag, "_sub_rsp"}, 64'(sub_if.rsp), 64'(0));
        check({tag, "_sub_rdt"}, 64'(sub_if.rdt), 64'(0));
        check({tag, "_sub_err"}, 64'(sub_if.err), 64'(0));
        check({tag, "_man_ben"}, 64'(man_if.ben), 64'(0));
        check({tag, "_man_adr"}, 64'(man_if.adr), 64'(0));
        check({tag, "_man_wen"}, 64'(man_if.wen), 64'(0));
        check({tag, "_man_wdt"}, 64'(man_if.wdt), 64'(0));
    endtask

    // Queue the expected beats, manager read data and subordinate response of one request.
    task automatic expect_req(input vec_t v, input bit with_rsp);
        beat_q.push_back('{adr: v.adr1, ben: v.ben1, wen: v.wen, wdt: v.mwdt});
        data_q.push_back('{rdt: v.rdt1, err: v.err1});
        if (v.nbeats == 2) begin
            beat_q.push_back('{adr: v.adr2, ben: v.ben2, wen: v.wen, wdt: v.mwdt});
            data_q.push_back('{rdt: v.rdt2, err: v.err2});
        end
        if (with_rsp) rsp_q.push_back('{rdt: v.exp_rdt, err: v.exp_err});
    endtask

    task automatic drive_fields(input vec_t v);
        sub_if.vld = 1'b1;
        sub_if.wen = v.wen;
        sub_if.adr = v.adr;
        sub_if.siz = v.siz;
        sub_if.wdt = v.wdt;
    endtask

    // Issue one request (called just after a rising edge) and wait for its handshake.
    task automatic send(input int idx, input vec_t v);
        int  stalls;
        bit  done;
        stalls = 0;
        done   = 1'b0;
        man_if.rdy = 1'b1;
        drive_fields(v);
        expect_req(v, 1'b1);
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (sub_if.rdy) done = 1'b1;
            else            stalls++;
            @(posedge clk);
            #1;
        end
        check($sformatf("v%0d_handshake", idx), 64'(done), 64'(1));
        check($sformatf("v%0d_stall", idx), 64'(stalls), 64'(v.stall));
    endtask

    // Manager model and scoreboard: checks beats and responses, returns read data one cycle after each beat.
    initial begin : manager
        logic       hs;
        data_t      nd;
        beat_t      eb;
        data_t      er;
        logic [31:0] mask;
        man_if.rdt = '0;
        man_if.err = 1'b0;
        forever begin
            @(negedge clk);
            hs = rst_n && man_if.vld && man_if.rdy;
            if (sub_if.rsp) begin
                n_rsp++;
                if (rsp_q.size() == 0) begin
                    check("unexpected_rsp", 64'(sub_if.rdt), 64'(0));
                    n_errors += (sub_if.rdt === '0) ? 1 : 0;
                    if (sub_if.rdt === '0) $display("FAIL unexpected_rsp: got rsp expected none");
                end else begin
                    er = rsp_q.pop_front();
                    check("rsp_rdt", 64'(sub_if.rdt), 64'(er.rdt));
                    check("rsp_err", 64'(sub_if.err), 64'(er.err));
                end
            end
            nd = '{rdt: '0, err: 1'b0};
            if (hs) begin
                if (beat_q.size() == 0) begin
                    check("unexpected_beat", 64'(man_if.adr), 64'(0));
                end else begin
                    eb = beat_q.pop_front();
                    for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{eb.ben[b]}};
                    check("beat_adr", 64'(man_if.adr), 64'(eb.adr));
                    check("beat_ben", 64'(man_if.ben), 64'(eb.ben));
                    check("beat_wen", 64'(man_if.wen), 64'(eb.wen));
                    check("beat_wdt", 64'(man_if.wdt & mask), 64'(eb.wdt & mask));
                end
                if (data_q.size() > 0) nd = data_q.pop_front();
            end
            @(posedge clk);
            #1;
            man_if.rdt = hs ? nd.rdt : '0;
            man_if.err = hs ? nd.err : 1'b0;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int rsp_before;
        n_checks = 0;
        n_errors = 0;
        n_rsp    = 0;
        rst_n      = 1'b0;
        sub_if.vld = 1'b0;
        sub_if.wen = 1'b0;
        sub_if.adr = '0;
        sub_if.siz = '0;
        sub_if.wdt = '0;
        man_if.rdy = 1'b1;

        //          wen   adr           siz  wdt           rdt1          rdt2          e1 e2 nb adr1          ben1     adr2          ben2     mwdt          exp_rdt       ee st
        vecs[0]  = '{1'b0, 32'h0000_0100, 2'd2, 32'h0,        32'hAABB_CCDD, 32'h0,        0, 0, 1, 32'h0000_0100, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'hAABB_CCDD, 0, 0};
        vecs[1]  = '{1'b1, 32'h0000_0103, 2'd0, 32'h5A,       32'h0,        32'h0,        0, 0, 1, 32'h0000_0100, 4'b1000, 32'h0,        4'b0000, 32'h5A00_0000, 32'h0,        0, 0};
        vecs[2]  = '{1'b0, 32'h0000_0102, 2'd2, 32'h0,        32'h1122_3344, 32'h5566_7788, 0, 0, 2, 32'h0000_0100, 4'b1100, 32'h0000_0104, 4'b0011, 32'h0,        32'h7788_1122, 0, 1};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFE, 2'd2, 32'hCAFE_BABE, 32'h0,        32'h0,        0, 0, 2, 32'hFFFF_FFFC, 4'b1100, 32'h0000_0000, 4'b0011, 32'hBABE_CAFE, 32'h0,        0, 1};
        vecs[4]  = '{1'b0, 32'h0000_0103, 2'd1, 32'h0,        32'hDE00_0000, 32'h0000_00AD, 1, 0, 2, 32'h0000_0100, 4'b1000, 32'h0000_0104, 4'b0001, 32'h0,        32'h0000_ADDE, 1, 1};
        vecs[5]  = '{1'b0, 32'h0000_0202, 2'd1, 32'h0,        32'h1234_5678, 32'h0,        0, 0, 1, 32'h0000_0200, 4'b1100, 32'h0,        4'b0000, 32'h0,        32'h0000_1234, 0, 0};
        vecs[6]  = '{1'b0, 32'h0000_0301, 2'd0, 32'h0,        32'hFFAB_FFFF, 32'h0,        0, 0, 1, 32'h0000_0300, 4'b0010, 32'h0,        4'b0000, 32'h0,        32'h0000_00FF, 0, 0};
        vecs[7]  = '{1'b0, 32'h0000_0400, 2'd2, 32'h0,        32'h0102_0304, 32'h0,        1, 0, 1, 32'h0000_0400, 4'b1111, 32'h0,        4'b0000, 32'h0,        32'h0102_0304, 1, 0};
        vecs[8]  = '{1'b0, 32'h0000_0107, 2'd1, 32'h0,        32'h9900_0000, 32'h0000_0088, 0, 1, 2, 32'h0000_0104, 4'b1000, 32'h0000_0108, 4'b0001, 32'h0,        32'h0000_8899, 1, 1};
        vecs[9]  = '{1'b1, 32'h0000_0101, 2'd1, 32'h1234_BEEF, 32'h0,        32'h0,        0, 0, 1, 32'h0000_0100, 4'b0110, 32'h0,        4'b0000, 32'h34BE_EF12, 32'h0,        0, 0};
        vecs[10] = '{1'b1, 32'h0000_0105, 2'd2, 32'h4433_2211, 32'h0,        32'h0,        0, 0, 2, 32'h0000_0104, 4'b1110, 32'h0000_0108, 4'b0001, 32'h3322_1144, 32'h0,        0, 1};

        // Reset state, with man_rdy high so a missing gate on sub_rdy would show.
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back table requests.
        for (int i = 0; i < NV; i++) send(i, vecs[i]);
        sub_if.vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("table_rsp_count", 64'(n_rsp), 64'(NV));
        check("table_rsp_q_empty", 64'(rsp_q.size()), 64'(0));
        check("table_beat_q_empty", 64'(beat_q.size()), 64'(0));

        // Split read with the manager stalling the second beat for three cycles.
        man_if.rdy = 1'b1;
        drive_fields(vecs[2]);
        expect_req(vecs[2], 1'b1);
        @(negedge clk);
        check("stall_first_rdy", 64'(sub_if.rdy), 64'(0));
        check("stall_first_adr", 64'(man_if.adr), 64'(32'h100));
        @(posedge clk);
        #1;
        man_if.rdy = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("stall_c%0d_man_vld", c), 64'(man_if.vld), 64'(1));
            check($sformatf("stall_c%0d_sub_rdy", c), 64'(sub_if.rdy), 64'(0));
            check($sformatf("stall_c%0d_man_adr", c), 64'(man_if.adr), 64'(32'h104));
            check($sformatf("stall_c%0d_man_ben", c), 64'(man_if.ben), 64'(4'b0011));
            @(posedge clk);
            #1;
        end
        man_if.rdy = 1'b1;
        @(negedge clk);
        check("stall_release_rdy", 64'(sub_if.rdy), 64'(1));
        @(posedge clk);
        #1;
        sub_if.vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("stall_rsp_count", 64'(n_rsp), 64'(NV + 1));
        check("stall_rsp_q_empty", 64'(rsp_q.size()), 64'(0));

        // Reset asserted while the second beat is pending: split abandoned, no response.
        rsp_before = n_rsp;
        man_if.rdy = 1'b1;
        drive_fields(vecs[2]);
        beat_q.push_back('{adr: vecs[2].adr1, ben: vecs[2].ben1, wen: 1'b0, wdt: 32'h0});
        data_q.push_back('{rdt: vecs[2].rdt1, err: vecs[2].err1});
        @(posedge clk);
        #1;
        man_if.rdy = 1'b0;
        @(negedge clk);
        check("rst_split_in_second", 64'(man_if.adr), 64'(32'h104));
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_held");
        rst_n      = 1'b1;
        sub_if.vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("rst_no_rsp", 64'(n_rsp), 64'(rsp_before));
        check("rst_beat_q_empty", 64'(beat_q.size()), 64'(0));
        check("rst_man_vld_idle", 64'(man_if.vld), 64'(0));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tcb_lib_logsize2byteena_split.md
Name: tcb_lib_logsize2byteena_split

Overview:
- Converts a TCB logarithmic-size request stream (subordinate side) into a byte-enable stream (manager side).
- Little-endian only.
- Any access whose byte range crosses a data-word boundary is split into two consecutive aligned manager transfers. The two read responses are merged back into one subordinate response.
- Sits between a CPU load/store unit that issues misaligned accesses and byte-enable memories or peripherals.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; a power of 2, at least 16. BEN=DW/8, MAX=log2(BEN), SW=clog2(MAX+1).
- DLY, 1, response delay in cycles from manager handshake to manager response; range 0..4. The same delay applies on the subordinate side.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- sub_vld  in  1  request valid
- sub_rdy  out  1  request ready
- sub_wen  in  1  write enable (0 = read)
- sub_adr  in  AW  byte address
- sub_siz  in  SW  log2 of access size in bytes
- sub_wdt  in  DW  write data, LSB-aligned
- sub_rsp  out  1  response strobe, DLY cycles after sub handshake
- sub_rdt  out  DW  read data, LSB-aligned, zero-filled above the access size
- sub_err  out  1  response error
- man_vld  out  1  request valid
- man_rdy  in  1  request ready
- man_wen  out  1  write enable
- man_adr  out  AW  word-aligned address (low MAX bits zero)
- man_ben  out  BEN  byte enables
- man_wdt  out  DW  write data, byte lanes rotated
- man_rdt  in  DW  read data, valid DLY cycles after man handshake
- man_err  in  1  error, valid with man_rdt

Behaviour:
- Definitions: off=sub_adr[MAX-1:0]; N=2**sub_siz; cross=(off+N>BEN). sub_siz>MAX is illegal: assertion fires, siz is clamped to MAX.
- Handshake: transfer occurs when vld&rdy on a clock edge. sub_vld and the request fields must stay stable while sub_rdy=0; an assertion checks this.
- FSM states: IDLE and SECOND.
- IDLE, cross=0:
  - man_vld=sub_vld, sub_rdy=man_rdy. Combinational pass-through, zero added request latency.
  - man_adr=aligned address; man_ben[i]=1 for off<=i<off+N.
- IDLE, cross=1:
  - man_vld=sub_vld, sub_rdy=0.
  - First beat: man_adr=aligned address; man_ben[i]=1 for i>=off.
  - On man handshake go to SECOND.
- SECOND:
  - man_vld=1 regardless of sub_vld; sub_rdy=man_rdy.
  - Second beat: man_adr=aligned+BEN, wrapping modulo 2^AW; man_ben[i]=1 for i<off+N-BEN.
  - On man handshake the sub handshake completes; go to IDLE.
  - If sub_vld dropped in SECOND, an assertion fires and the beat is still issued.
- Write data: man_wdt byte i = sub_wdt byte (i-off) mod BEN in every beat. man_wen=sub_wen in both beats.
- Response pipeline:
  - A DLY-deep shift register records, per man handshake, {first, last, off, siz}. Single beats record first=last=1.
  - On a record with first=1, last=0: capture man_rdt into hold register H and man_err into E. sub_rsp stays 0.
  - On a record with last=1: sub_rsp=1.
    - Merged byte k = (split and k>=off) ? H[k] : man_rdt[k].
    - sub_rdt byte j = merged byte (j+off) mod BEN for j<N, else 0.
    - sub_err = man_err | (split & E).
  - DLY=0: capture and response use the same cycle, combinationally.
- Back-to-back: a new request may be accepted in the cycle after a sub handshake. H is only overwritten by the next first-of-split record, which lands at least one cycle after the previous last record consumed it.
- Reset (asynchronous, rst_n=0): FSM=IDLE; pipeline, H and E cleared.
  - Outputs during reset: sub_rdy=0, man_vld=0, sub_rsp=0, sub_rdt=0, sub_err=0, man_ben=0, man_adr=0, man_wen=0, man_wdt=0.
  - A split interrupted by reset is abandoned; no response is produced for it.

Test Plan (DW=32, DLY=1):
- Aligned word read adr=0x100, siz=2, man_rdt=0xAABBCCDD -> one man beat adr=0x100, ben=1111; sub_rdt=0xAABBCCDD one cycle later; no stall.
- Byte write adr=0x103, siz=0, wdt=0x5A -> man ben=1000, man_wdt[31:24]=0x5A, single beat.
- Misaligned word read adr=0x102, siz=2; beat 1 rdt=0x11223344, beat 2 rdt=0x55667788:
  - Beats: adr=0x100 ben=1100, then adr=0x104 ben=0011.
  - sub_rdy low for 1 cycle; sub_rdt=0x77881122, sub_rsp once.
- Same split with man_rdy=0 for 3 cycles in SECOND -> H holds 0x1122 bytes; merged result unchanged; man_vld held high.
- Split write adr=0xFFFFFFFE, siz=2, wdt=0xCAFEBABE -> beats adr=0xFFFFFFFC ben=1100 wdt=0xBABExxxx, then adr=0x00000000 ben=0011 wdt=0xxxxxCAFE.
- Split read, beat 1 man_err=1 -> sub_err=1. Separately, assert rst_n low while in SECOND -> FSM IDLE, all outputs 0, no sub_rsp after release.
